// File: rtl/pulse_shortener_pkg.sv
// Shared definitions for the pulse shortener: FSM encodings and counter sizing.
package pulse_shortener_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ACTIVE   = 2'd1;
   localparam logic [1:0] ST_WAIT_LOW = 2'd2;
   localparam logic [1:0] ST_HOLDOFF  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE     = ST_IDLE,
      S_ACTIVE   = ST_ACTIVE,
      S_WAIT_LOW = ST_WAIT_LOW,
      S_HOLDOFF  = ST_HOLDOFF
   } ps_state_e;

   function automatic int ps_cnt_width(input int pulse_length, input int holdoff);
      int m;
      m = (pulse_length > holdoff) ? pulse_length : holdoff;
      return (m + 1 > 1) ? $clog2(m + 1) : 1;
   endfunction

endpackage

// File: rtl/pulse_shortener_rising_edge_detector.sv
// Registered previous-value edge detector; prev clears on reset so a held-high
// input is seen as a rising edge at the first clock after release.
module rising_edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic sig_in,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) prev <= 1'b0;
      else       prev <= sig_in;
   end

   assign rise = sig_in & ~prev;

endmodule

// File: rtl/pulse_shortener.sv
// Regenerates a bounded pulse of at most PULSE_LENGTH cycles with a hold-off gap.
// Optional input-width measurement: define PULSE_SHORTENER_WIDTH_MEASURE_EN.
module pulse_shortener
   import pulse_shortener_pkg::*;
#(
   parameter int PULSE_LENGTH = 1,
   parameter int HOLDOFF      = 0,
   parameter int WIDTH_WIDTH  = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   pulse_in,
   output logic                   pulse_out,
   output logic                   truncated,
   output logic                   dropped,
   output logic [WIDTH_WIDTH-1:0] width_value,
   output logic                   width_valid,
   output logic                   width_overflow
);

   localparam int CNT_W = ps_cnt_width(PULSE_LENGTH, HOLDOFF);
   localparam logic [CNT_W-1:0] PL_LOAD = CNT_W'(PULSE_LENGTH - 1);
   localparam logic [CNT_W-1:0] HO_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   ps_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             rise;
   logic             trunc_nxt;
   logic             drop_nxt;

   rising_edge_detector u_edge (
      .clock  (clock),
      .reset  (reset),
      .sig_in (pulse_in),
      .rise   (rise)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      trunc_nxt = 1'b0;
      drop_nxt  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (rise) begin
               state_nxt = S_ACTIVE;
               cnt_nxt   = PL_LOAD;
            end
         end
         S_ACTIVE, S_WAIT_LOW: begin
            if (!pulse_in) begin
               if (HOLDOFF == 0) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_HOLDOFF;
                  cnt_nxt   = HO_LOAD;
               end
            end else if (state == S_ACTIVE) begin
               if (cnt == '0) begin
                  state_nxt = S_WAIT_LOW;
                  trunc_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end
         end
         S_HOLDOFF: begin
            // Edges here are swallowed, including the one on the exiting clock.
            drop_nxt = rise;
            if (cnt == '0) state_nxt = S_IDLE;
            else           cnt_nxt   = cnt - CNT_ONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         pulse_out <= 1'b0;
         truncated <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pulse_out <= (state_nxt == S_ACTIVE);
         truncated <= trunc_nxt;
         dropped   <= drop_nxt;
      end
   end

`ifdef PULSE_SHORTENER_WIDTH_MEASURE_EN
   localparam logic [WIDTH_WIDTH-1:0] W_MAX = '1;
   localparam logic [WIDTH_WIDTH-1:0] W_ONE = WIDTH_WIDTH'(1);

   logic [WIDTH_WIDTH-1:0] wcnt;
   logic                   wsat;
   logic                   meas_busy;
   logic                   meas_done;

   // Returns {saturated, count}; saturated sticks once an increment is lost.
   function automatic logic [WIDTH_WIDTH:0] sat_inc(input logic sat_in,
                                                    input logic [WIDTH_WIDTH-1:0] v);
      if (v == W_MAX) return {1'b1, v};
      return {sat_in, v + W_ONE};
   endfunction

   assign meas_busy = (state == S_ACTIVE) || (state == S_WAIT_LOW);
   assign meas_done = meas_busy && !pulse_in;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wcnt           <= '0;
         wsat           <= 1'b0;
         width_value    <= '0;
         width_valid    <= 1'b0;
         width_overflow <= 1'b0;
      end else begin
         width_valid <= meas_done;
         if (state == S_IDLE && rise) begin
            wcnt <= W_ONE;
            wsat <= 1'b0;
         end else if (meas_busy && pulse_in) begin
            {wsat, wcnt} <= sat_inc(wsat, wcnt);
         end
         if (meas_done) begin
            width_value    <= wcnt;
            width_overflow <= wsat;
         end
      end
   end
`else
   assign width_value    = '0;
   assign width_valid    = 1'b0;
   assign width_overflow = 1'b0;
`endif

endmodule
